// File: rtl/flit_sink_checker.sv
// Destination-side flit sink: checks routing and per-source sequence order,
// counts traffic, and captures accepted flits in a drainable FIFO.
module flit_sink_checker #(
    parameter int MY_CLUSTER = 0,
    parameter int MY_LOCAL   = 0,
    parameter int NUM_SRC    = 4,
    parameter int EXPECTED   = 30,
    parameter int FIFO_DEPTH = 32,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [19:0]      datain,
    input  logic             in_valid,
    input  logic             rd_en,
    output logic [19:0]      rd_data,
    output logic             rd_valid,
    output logic             fifo_empty,
    output logic             fifo_full,
    output logic [CNT_W-1:0] rx_count,
    output logic [CNT_W-1:0] seq_err_count,
    output logic [CNT_W-1:0] misroute_count,
    output logic             overflow,
    output logic             done,
    output logic             error
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic        extra;
    logic [7:0]  expected_seq [NUM_SRC];
    logic [19:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   occ, occ_next;

    logic [7:0] src_id, payload, seq_exp;
    logic       accept, misroute, bad_src, seq_ok, push, pop, hit_expected;
    logic [CNT_W-1:0] rx_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    assign src_id  = datain[19:12];
    assign payload = datain[11:4];

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        seq_exp = 8'h00;
        for (int s = 0; s < NUM_SRC; s++)
            if (src_id == 8'(s)) seq_exp = expected_seq[s];
        accept       = in_valid && enable && (state == RUN);
        misroute     = (datain[3:2] != 2'(MY_CLUSTER)) || (datain[1:0] != 2'(MY_LOCAL));
        bad_src      = 32'(src_id) >= NUM_SRC;
        seq_ok       = (payload == seq_exp);
        pop          = rd_en && !fifo_empty;
        // A full FIFO still accepts a write when the same cycle pops.
        push         = accept && (!fifo_full || rd_en);
        rx_next      = sat_inc(rx_count);
        hit_expected = (32'(rx_next) == EXPECTED);
        occ_next     = occ;
        if (push && !pop)      occ_next = occ + 1'b1;
        else if (pop && !push) occ_next = occ - 1'b1;
    end

    assign error = overflow | extra | (seq_err_count != '0) | (misroute_count != '0);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            extra          <= 1'b0;
            rd_data        <= '0;
            rd_valid       <= 1'b0;
            fifo_empty     <= 1'b1;
            fifo_full      <= 1'b0;
            rx_count       <= '0;
            seq_err_count  <= '0;
            misroute_count <= '0;
            overflow       <= 1'b0;
            done           <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            occ            <= '0;
            for (int s = 0; s < NUM_SRC; s++) expected_seq[s] <= 8'h01;
        end else begin
            rd_valid <= pop;
            if (pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            occ        <= occ_next;
            fifo_empty <= (occ_next == '0);
            fifo_full  <= (occ_next == (AW+1)'(FIFO_DEPTH));

            case (state)
                IDLE: if (enable) state <= RUN;
                RUN: begin
                    if (accept && hit_expected) state <= DONE;
                    else if (!enable)           state <= IDLE;
                end
                DONE: if (in_valid) extra <= 1'b1;
                default: state <= IDLE;
            endcase

            if (accept) begin
                rx_count <= rx_next;
                if (hit_expected) done <= 1'b1;
                if (fifo_full && !rd_en) overflow <= 1'b1;
                // Misrouted flits bypass source and ordering checks entirely.
                if (misroute) begin
                    misroute_count <= sat_inc(misroute_count);
                end else if (bad_src) begin
                    seq_err_count <= sat_inc(seq_err_count);
                end else begin
                    if (!seq_ok) seq_err_count <= sat_inc(seq_err_count);
                    for (int s = 0; s < NUM_SRC; s++)
                        if (src_id == 8'(s)) expected_seq[s] <= payload + 8'h01;
                end
            end
        end
    end

    // NOTE: the storage array has no reset; only pointers and flags define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= datain;
    end

endmodule

// File: tb/tb_flit_sink_checker.sv
// Directed bench for flit_sink_checker: default instance plus a 4-entry FIFO
// instance for the overflow scenarios.
module tb_flit_sink_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable, in_valid, rd_en;
    logic [19:0] datain, rd_data;
    logic        rd_valid, fifo_empty, fifo_full, overflow, done, error;
    logic [7:0]  rx_count, seq_err_count, misroute_count;

    logic        s_enable, s_in_valid, s_rd_en;
    logic [19:0] s_datain, s_rd_data;
    logic        s_rd_valid, s_fifo_empty, s_fifo_full, s_overflow, s_done, s_error;
    logic [7:0]  s_rx_count, s_seq_err_count, s_misroute_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    flit_sink_checker dut (
        .clk(clk), .rst(rst), .enable(enable), .datain(datain), .in_valid(in_valid),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .rx_count(rx_count), .seq_err_count(seq_err_count),
        .misroute_count(misroute_count), .overflow(overflow), .done(done), .error(error)
    );

    flit_sink_checker #(.FIFO_DEPTH(4)) dut_small (
        .clk(clk), .rst(rst), .enable(s_enable), .datain(s_datain), .in_valid(s_in_valid),
        .rd_en(s_rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .fifo_empty(s_fifo_empty),
        .fifo_full(s_fifo_full), .rx_count(s_rx_count), .seq_err_count(s_seq_err_count),
        .misroute_count(s_misroute_count), .overflow(s_overflow), .done(s_done), .error(s_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] mk(input logic [7:0] src, input logic [7:0] pay);
        return {src, pay, 4'h0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [19:0] f);
        datain = f; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic s_send(input logic [19:0] f);
        s_datain = f; s_in_valid = 1'b1;
        tick();
        s_in_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [19:0] exp);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
        chk(tag, 32'(rd_data), 32'(exp));
    endtask

    task automatic s_pop_check(input string tag, input logic [19:0] exp);
        s_rd_en = 1'b1;
        tick();
        s_rd_en = 1'b0;
        chk({tag, "_valid"}, 32'(s_rd_valid), 32'd1);
        chk(tag, 32'(s_rd_data), 32'(exp));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        enable = 1'b0; in_valid = 1'b0; rd_en = 1'b0; datain = '0;
        s_enable = 1'b0; s_in_valid = 1'b0; s_rd_en = 1'b0; s_datain = '0;
        #3;
        @(negedge clk) rst = 1'b1;
        tick();
    endtask

    logic [19:0] gap_flits [6];

    initial begin
        gap_flits[0] = 20'h01010; gap_flits[1] = 20'h01020; gap_flits[2] = 20'h01040;
        gap_flits[3] = 20'h01050; gap_flits[4] = 20'h01061; gap_flits[5] = 20'h01060;

        // Reset values
        rst = 1'b0;
        enable = 1'b0; in_valid = 1'b0; rd_en = 1'b0; datain = '0;
        s_enable = 1'b0; s_in_valid = 1'b0; s_rd_en = 1'b0; s_datain = '0;
        #12;
        chk("rst_rx", 32'(rx_count), 32'd0);
        chk("rst_empty", 32'(fifo_empty), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_s_empty", 32'(s_fifo_empty), 32'd1);
        @(negedge clk) rst = 1'b1;
        tick();

        // Flits while disabled are ignored
        for (int i = 0; i < 3; i++) send(mk(8'h01, 8'(i + 1)));
        chk("dis_rx", 32'(rx_count), 32'd0);
        chk("dis_empty", 32'(fifo_empty), 32'd1);

        // Nominal 30-flit stream
        enable = 1'b1;
        tick();
        for (int i = 0; i < 30; i++) begin
            send(mk(8'h01, 8'(i + 1)));
            if (i == 28) chk("nom_done_early", 32'(done), 32'd0);
        end
        chk("nom_rx", 32'(rx_count), 32'd30);
        chk("nom_done", 32'(done), 32'd1);
        chk("nom_seq", 32'(seq_err_count), 32'd0);
        chk("nom_mis", 32'(misroute_count), 32'd0);
        chk("nom_error", 32'(error), 32'd0);
        chk("nom_full", 32'(fifo_full), 32'd0);

        // Extra flit in DONE: not counted or captured, sets error
        send(mk(8'h01, 8'd31));
        chk("extra_rx", 32'(rx_count), 32'd30);
        chk("extra_error", 32'(error), 32'd1);
        for (int i = 0; i < 30; i++) pop_check("nom_pop", mk(8'h01, 8'(i + 1)));
        chk("nom_drained", 32'(fifo_empty), 32'd1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("empty_pop_valid", 32'(rd_valid), 32'd0);
        chk("empty_pop_hold", 32'(rd_data), 32'h011E0);

        // Gap plus misroute
        do_reset();
        enable = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) send(gap_flits[i]);
        chk("gap_seq", 32'(seq_err_count), 32'd1);
        chk("gap_mis", 32'(misroute_count), 32'd1);
        chk("gap_rx", 32'(rx_count), 32'd5);
        chk("gap_error", 32'(error), 32'd1);
        send(gap_flits[5]);
        chk("gap_resync_seq", 32'(seq_err_count), 32'd1);
        for (int i = 0; i < 6; i++) pop_check("gap_pop", gap_flits[i]);
        chk("gap_drained", 32'(fifo_empty), 32'd1);

        // Bad source id
        do_reset();
        enable = 1'b1;
        tick();
        send(20'h05010);
        chk("bad_seq", 32'(seq_err_count), 32'd1);
        chk("bad_rx", 32'(rx_count), 32'd1);
        chk("bad_mis", 32'(misroute_count), 32'd0);
        chk("bad_nonempty", 32'(fifo_empty), 32'd0);
        pop_check("bad_pop", 20'h05010);

        // Async reset mid-stream
        do_reset();
        enable = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) send(mk(8'h01, 8'(i + 1)));
        for (int i = 0; i < 3; i++) pop_check("ar_pop", mk(8'h01, 8'(i + 1)));
        rd_en = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        chk("ar_rx", 32'(rx_count), 32'd0);
        chk("ar_rd_valid", 32'(rd_valid), 32'd0);
        chk("ar_rd_data", 32'(rd_data), 32'd0);
        chk("ar_empty", 32'(fifo_empty), 32'd1);
        chk("ar_error", 32'(error), 32'd0);
        rd_en = 1'b0;
        @(negedge clk) rst = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) send(mk(8'h01, 8'(i + 1)));
        chk("ar_restart_seq", 32'(seq_err_count), 32'd0);
        chk("ar_restart_rx", 32'(rx_count), 32'd5);
        pop_check("ar_restart_pop", mk(8'h01, 8'd1));

        // Overflow on the 4-entry instance
        do_reset();
        s_enable = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) s_send(mk(8'h01, 8'(i + 1)));
        chk("ov_full4", 32'(s_fifo_full), 32'd1);
        chk("ov_none4", 32'(s_overflow), 32'd0);
        s_send(mk(8'h01, 8'd5));
        chk("ov_set5", 32'(s_overflow), 32'd1);
        chk("ov_error", 32'(s_error), 32'd1);
        s_send(mk(8'h01, 8'd6));
        chk("ov_rx", 32'(s_rx_count), 32'd6);
        chk("ov_seq", 32'(s_seq_err_count), 32'd0);
        s_pop_check("ov_pop1", 20'h01010);
        chk("ov_notfull", 32'(s_fifo_full), 32'd0);
        s_send(20'h01070);
        chk("ov_refull", 32'(s_fifo_full), 32'd1);
        s_datain = 20'h01080; s_in_valid = 1'b1; s_rd_en = 1'b1;
        tick();
        s_in_valid = 1'b0; s_rd_en = 1'b0;
        chk("ov_pp_data", 32'(s_rd_data), 32'h01020);
        chk("ov_pp_full", 32'(s_fifo_full), 32'd1);
        s_pop_check("ov_drain", 20'h01030);
        s_pop_check("ov_drain", 20'h01040);
        s_pop_check("ov_drain", 20'h01070);
        s_pop_check("ov_drain", 20'h01080);
        chk("ov_drained", 32'(s_fifo_empty), 32'd1);
        chk("ov_done", 32'(s_done), 32'd0);
        chk("ov_mis", 32'(s_misroute_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
